// File: rtl/multi_sync_filter_pkg.sv
// Shared helpers for the multi-channel synchronizer / glitch filter.
// Only the filter counter width lives here.
package multi_sync_filter_pkg;

    function automatic int cnt_w(input int filt);
        return (filt > 2) ? $clog2(filt) : 1;
    endfunction

endpackage

// File: rtl/multi_sync_filter_ch.sv
// One channel: STAGE-deep synchronizer, FILT-sample stability filter, rise/fall pulse registers.
// Latency STAGE+FILT edges from capture to O level/pulse; no backpressure (free-running sampler).
module sync_filter_ch
    import multi_sync_filter_pkg::*;
#(
    parameter int   STAGE   = 3,
    parameter int   FILT    = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic commit
);

    localparam int            CW     = cnt_w(FILT);
    localparam logic [CW-1:0] C_LAST = CW'(FILT - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGE-1:0] q;
    logic [CW-1:0] cnt;
    logic          s;

    // Pure flop chain: nothing may sit between stages or MTBF suffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= {STAGE{RST_VAL}};
        else        q <= {q[STAGE-2:0], din};
    end

    assign s      = q[STAGE-1];
    assign commit = (s != level) && (cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= RST_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= commit & s;
            fall <= commit & ~s;
            // A matching sample restarts the count, so short pulses never commit.
            if (s == level) begin
                cnt <= '0;
            end else if (commit) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_sync_filter.sv
// CH independent synchronizer/filter channels plus a registered any-change flag.
// Latency STAGE+FILT edges from capture; no backpressure. Reset release assumed synchronous to I_CLK.
module multi_sync_filter
    import multi_sync_filter_pkg::*;
#(
    parameter int          CH      = 4,
    parameter int          STAGE   = 3,
    parameter int          FILT    = 4,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic [CH-1:0] I_DATA,
    output logic [CH-1:0] O_DATA,
    output logic [CH-1:0] O_RISE,
    output logic [CH-1:0] O_FALL,
    output logic          O_CHG
);

    logic [CH-1:0] commit;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGE   (STAGE),
            .FILT    (FILT),
            .RST_VAL (RST_VAL[i])
        ) u_ch (
            .clk    (I_CLK),
            .rst_n  (I_RST_N),
            .din    (I_DATA[i]),
            .level  (O_DATA[i]),
            .rise   (O_RISE[i]),
            .fall   (O_FALL[i]),
            .commit (commit[i])
        );
    end

    // Registered from the same commit terms as the pulses, so it lines up with them.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) O_CHG <= 1'b0;
        else          O_CHG <= |commit;
    end

endmodule
